// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register banks: stage states,
// default geometry, and state-decode helpers used by every stage instance.
package pipe_pkg;

  localparam int PIPE_WIDTH = 64;
  localparam int PIPE_NCH   = 3;
  localparam int PIPE_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  // Handshake flags are decoded from the state the stage will be in next,
  // so the top can register them alongside the state itself.
  function automatic logic state_has_data(input pipe_state_e s);
    return (s != EMPTY);
  endfunction

  function automatic logic state_has_room(input pipe_state_e s);
    return (s != TWO);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_bank_reg.sv
// NCH x WIDTH register bank with load enable and synchronous clear.
// Each channel is an independent bit lane; no arithmetic on the data.
module pipe_bank_reg #(
  parameter int WIDTH = 64,
  parameter int NCH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      en,
  input  logic [NCH-1:0][WIDTH-1:0] d,
  output logic [NCH-1:0][WIDTH-1:0] q
);

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        q[c] <= '0;
      end else if (en) begin
        q[c] <= d[c];
      end
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int NCH   = PIPE_NCH
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int CNT_W = PIPE_CNT_W
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NCH-1:0][WIDTH-1:0] din,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NCH-1:0][WIDTH-1:0] dout
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
`endif
);

  pipe_state_e               state;
  pipe_state_e               state_next;
  logic                      accept;
  logic                      take;
  logic                      main_en;
  logic                      main_from_skid;
  logic                      skid_en;
  logic [NCH-1:0][WIDTH-1:0] main_d;
  logic [NCH-1:0][WIDTH-1:0] skid_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // The main register always holds the oldest entry; the skid only fills when
  // a new entry arrives while the main one is still waiting downstream.
  always_comb begin
    state_next     = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_en    = 1'b1;
        end
      end
      ONE: begin
        if (accept && take) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          skid_en    = 1'b1;
        end else if (take) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_next     = ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  assign main_d = main_from_skid ? skid_q : din;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_next;
      out_valid <= state_has_data(state_next);
      in_ready  <= state_has_room(state_next);
    end
  end

  pipe_bank_reg #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .en   (main_en),
    .d    (main_d),
    .q    (dout)
  );

  pipe_bank_reg #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .clr  (flush),
    .en   (skid_en),
    .d    (din),
    .q    (skid_q)
  );

`ifdef PIPE_STAGE_STATS_EN
  // Saturating counters; flush inserts a bubble but keeps the history.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
